// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus bundle.
// Groups the issue, CDB writeback, operand query, commit and flush signals
// between the reorder buffer and its neighbours.
//   slave  : the reorder buffer side (consumes issue/CDB/query, drives commit/flush)
//   master : the surrounding pipeline side (drives issue/CDB/query, consumes commit/flush)
interface reorder_buffer_if #(
    parameter int ROB_SIZE_BIT = 3
);
    localparam int SB = ROB_SIZE_BIT;

    // issue
    logic          issue_valid;
    logic [1:0]    issue_type;
    logic [4:0]    issue_rd;
    logic [31:0]   issue_pc;
    logic          issue_pred_taken;
    logic [SB-1:0] issue_rob_id;
    logic          rob_full;
    // CDB writeback
    logic          alu_valid;
    logic [SB-1:0] alu_id;
    logic [31:0]   alu_val;
    logic          alu_taken;
    logic          lsb_valid;
    logic [SB-1:0] lsb_id;
    logic [31:0]   lsb_val;
    // operand query
    logic [SB-1:0] qry_id1;
    logic [SB-1:0] qry_id2;
    logic          qry_ready1;
    logic          qry_ready2;
    logic [31:0]   qry_val1;
    logic [31:0]   qry_val2;
    // commit / flush
    logic [4:0]    rob_set_idx;
    logic [31:0]   rob_set_reg_val;
    logic [SB-1:0] rob_set_recorder;
    logic          store_commit;
    logic [SB-1:0] store_commit_id;
    logic          rob_clear;
    logic [31:0]   clear_pc;

    modport slave (
        input  issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
        output issue_rob_id, rob_full,
        input  alu_valid, alu_id, alu_val, alu_taken,
        input  lsb_valid, lsb_id, lsb_val,
        input  qry_id1, qry_id2,
        output qry_ready1, qry_ready2, qry_val1, qry_val2,
        output rob_set_idx, rob_set_reg_val, rob_set_recorder,
        output store_commit, store_commit_id, rob_clear, clear_pc
    );

    modport master (
        output issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
        input  issue_rob_id, rob_full,
        output alu_valid, alu_id, alu_val, alu_taken,
        output lsb_valid, lsb_id, lsb_val,
        output qry_id1, qry_id2,
        input  qry_ready1, qry_ready2, qry_val1, qry_val2,
        input  rob_set_idx, rob_set_reg_val, rob_set_recorder,
        input  store_commit, store_commit_id, rob_clear, clear_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order retirement queue.
// Allocates one entry per issued instruction at the tail, captures results
// from the ALU and LSB CDB ports, and retires the head entry in order (at
// most one per cycle). Retirement drives the register-file commit port, a
// store-commit pulse, or, for a mispredicted branch, a flush pulse with a
// redirect PC that also empties the queue.
// Ports:
//   i_clk  : clock, all state on posedge
//   i_rst  : synchronous active-high reset
//   i_rdy  : low freezes all state and outputs
//   io_rob : reorder_buffer_if.slave bundle (issue, CDB, query, commit, flush)
module reorder_buffer #(
    parameter int ROB_SIZE_BIT = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rdy,
    reorder_buffer_if.slave  io_rob
);
    localparam int SB   = ROB_SIZE_BIT;
    localparam int SIZE = 1 << SB;
    localparam logic [SB:0] FULL_CNT = (SB+1)'(SIZE);
    localparam logic [1:0]  T_BRANCH = 2'd1;
    localparam logic [1:0]  T_STORE  = 2'd2;

    // per-entry state
    logic [SIZE-1:0] r_busy;
    logic [SIZE-1:0] r_ready;
    logic [SIZE-1:0] r_pred;
    logic [SIZE-1:0] r_real;
    logic [1:0]      r_type [SIZE];
    logic [4:0]      r_rd   [SIZE];
    logic [31:0]     r_val  [SIZE];
    logic [31:0]     r_pc   [SIZE];

    logic [SB-1:0]   r_head;
    logic [SB-1:0]   r_tail;
    logic [SB:0]     r_count;

    // registered outputs
    logic [4:0]      r_set_idx;
    logic [31:0]     r_set_val;
    logic [SB-1:0]   r_set_rec;
    logic            r_store_commit;
    logic [SB-1:0]   r_store_id;
    logic            r_clear;
    logic [31:0]     r_clear_pc;

    logic            w_full;
    logic            w_issue;
    logic            w_commit;
    logic            w_mispred;
    logic            w_alu_hit;
    logic            w_lsb_hit;

    assign w_full    = (r_count == FULL_CNT);
    assign w_issue   = io_rob.issue_valid && !w_full;
    assign w_commit  = r_busy[r_head] && r_ready[r_head];
    assign w_mispred = w_commit && (r_type[r_head] == T_BRANCH) &&
                       (r_real[r_head] != r_pred[r_head]);
    // busy is sampled pre-edge, so a result for a retired or never-issued
    // tag is dropped
    assign w_alu_hit = io_rob.alu_valid && r_busy[io_rob.alu_id];
    assign w_lsb_hit = io_rob.lsb_valid && r_busy[io_rob.lsb_id];

    assign io_rob.issue_rob_id     = r_tail;
    assign io_rob.rob_full         = w_full;
    assign io_rob.qry_ready1       = r_busy[io_rob.qry_id1] && r_ready[io_rob.qry_id1];
    assign io_rob.qry_ready2       = r_busy[io_rob.qry_id2] && r_ready[io_rob.qry_id2];
    assign io_rob.qry_val1         = r_val[io_rob.qry_id1];
    assign io_rob.qry_val2         = r_val[io_rob.qry_id2];
    assign io_rob.rob_set_idx      = r_set_idx;
    assign io_rob.rob_set_reg_val  = r_set_val;
    assign io_rob.rob_set_recorder = r_set_rec;
    assign io_rob.store_commit     = r_store_commit;
    assign io_rob.store_commit_id  = r_store_id;
    assign io_rob.rob_clear        = r_clear;
    assign io_rob.clear_pc         = r_clear_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_busy         <= '0;
            r_ready        <= '0;
            r_pred         <= '0;
            r_real         <= '0;
            for (int i = 0; i < SIZE; i++) begin
                r_type[i] <= '0;
                r_rd[i]   <= '0;
                r_val[i]  <= '0;
                r_pc[i]   <= '0;
            end
            r_set_idx      <= '0;
            r_set_val      <= '0;
            r_set_rec      <= '0;
            r_store_commit <= 1'b0;
            r_store_id     <= '0;
            r_clear        <= 1'b0;
            r_clear_pc     <= '0;
        end else if (i_rdy) begin
            // pulses default low on every active cycle
            r_set_idx      <= '0;
            r_store_commit <= 1'b0;
            r_clear        <= 1'b0;
            if (w_mispred) begin
                // flush: same-cycle issue and writebacks are discarded
                r_clear    <= 1'b1;
                r_clear_pc <= r_real[r_head] ? r_val[r_head] : r_pc[r_head] + 32'd4;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_busy     <= '0;
                r_ready    <= '0;
            end else begin
                if (w_alu_hit) begin
                    r_ready[io_rob.alu_id] <= 1'b1;
                    r_val[io_rob.alu_id]   <= io_rob.alu_val;
                    r_real[io_rob.alu_id]  <= io_rob.alu_taken;
                end
                // placed after the ALU update so LSB wins on a shared id
                if (w_lsb_hit) begin
                    r_ready[io_rob.lsb_id] <= 1'b1;
                    r_val[io_rob.lsb_id]   <= io_rob.lsb_val;
                end
                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + 1'b1;
                    r_set_rec       <= r_head;
                    r_set_val       <= r_val[r_head];
                    if (r_type[r_head] == T_STORE) begin
                        r_store_commit <= 1'b1;
                        r_store_id     <= r_head;
                    end else if (r_type[r_head] != T_BRANCH) begin
                        r_set_idx <= r_rd[r_head];
                    end
                end
                // tail != head whenever both issue and commit happen
                // (queue neither empty nor full), so no slot collides
                if (w_issue) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_type[r_tail]  <= io_rob.issue_type;
                    r_rd[r_tail]    <= io_rob.issue_rd;
                    r_pc[r_tail]    <= io_rob.issue_pc;
                    r_pred[r_tail]  <= io_rob.issue_pred_taken;
                    r_real[r_tail]  <= 1'b0;
                    r_tail          <= r_tail + 1'b1;
                end
                if (w_issue && !w_commit) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_issue && w_commit) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end
endmodule
